// File: rtl/tick_window_accumulator.sv
// Accumulates signed samples over each period of the derived clock and reports sum/count/overflow at every rising edge.
// Optional per-window min/max outputs are enabled by defining TICK_ACC_MINMAX_EN.
module tick_window_accumulator #(
  parameter int DATA_WIDTH = 14,
  parameter int ACC_WIDTH  = 32,
  parameter int CNT_WIDTH  = 24
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         derived_clk,
  input  logic signed [DATA_WIDTH-1:0] data_i,
  input  logic                         data_valid_i,
  output logic signed [ACC_WIDTH-1:0]  sum_o,
  output logic        [CNT_WIDTH-1:0]  count_o,
  output logic                         overflow_o,
  output logic                         valid_o
`ifdef TICK_ACC_MINMAX_EN
  ,
  output logic signed [DATA_WIDTH-1:0] min_o,
  output logic signed [DATA_WIDTH-1:0] max_o
`endif
);

  typedef enum logic {
    ST_WAIT  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  state_t                        state_q, state_d;
  logic                          prev_q, prev_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic        [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                          ovf_q, ovf_d;
  logic signed [ACC_WIDTH-1:0]   sum_q, sum_d;
  logic        [CNT_WIDTH-1:0]   count_q, count_d;
  logic                          overflow_q, overflow_d;
  logic                          valid_q, valid_d;

  logic                          edge_det;
  logic signed [ACC_WIDTH-1:0]   sample_ext;
  logic        [ACC_WIDTH:0]     sum_wide;
  logic                          acc_clamp;
  logic signed [ACC_WIDTH-1:0]   acc_next;
  logic                          cnt_full;
  logic        [CNT_WIDTH-1:0]   cnt_next;
  logic signed [ACC_WIDTH-1:0]   acc_start;
  logic        [CNT_WIDTH-1:0]   cnt_start;

`ifdef TICK_ACC_MINMAX_EN
  localparam logic signed [DATA_WIDTH-1:0] DATA_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] DATA_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic signed [DATA_WIDTH-1:0]  win_min_q, win_min_d;
  logic signed [DATA_WIDTH-1:0]  win_max_q, win_max_d;
  logic signed [DATA_WIDTH-1:0]  min_out_q, min_out_d;
  logic signed [DATA_WIDTH-1:0]  max_out_q, max_out_d;
`endif

  assign edge_det   = derived_clk & ~prev_q;
  assign sample_ext = {{(ACC_WIDTH-DATA_WIDTH){data_i[DATA_WIDTH-1]}}, data_i};

  // One extra bit lets the carry-out reveal signed overflow before clamping.
  assign sum_wide  = {acc_q[ACC_WIDTH-1], acc_q} + {sample_ext[ACC_WIDTH-1], sample_ext};
  assign acc_clamp = sum_wide[ACC_WIDTH] ^ sum_wide[ACC_WIDTH-1];
  assign acc_next  = acc_clamp ? (sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX)
                               : sum_wide[ACC_WIDTH-1:0];

  assign cnt_full = &cnt_q;
  assign cnt_next = cnt_full ? cnt_q : cnt_q + CNT_WIDTH'(1);

  // A sample arriving in the edge cycle opens the new window.
  assign acc_start = data_valid_i ? sample_ext : '0;
  assign cnt_start = {{(CNT_WIDTH-1){1'b0}}, data_valid_i};

  always_comb begin
    state_d    = state_q;
    prev_d     = derived_clk;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    sum_d      = sum_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    valid_d    = 1'b0;
`ifdef TICK_ACC_MINMAX_EN
    win_min_d  = win_min_q;
    win_max_d  = win_max_q;
    min_out_d  = min_out_q;
    max_out_d  = max_out_q;
`endif

    case (state_q)
      ST_WAIT: begin
        if (edge_det) begin
          state_d = ST_ACCUM;
          acc_d   = acc_start;
          cnt_d   = cnt_start;
          ovf_d   = 1'b0;
`ifdef TICK_ACC_MINMAX_EN
          win_min_d = data_valid_i ? data_i : DATA_MAX;
          win_max_d = data_valid_i ? data_i : DATA_MIN;
`endif
        end
      end

      ST_ACCUM: begin
        if (edge_det) begin
          sum_d      = acc_q;
          count_d    = cnt_q;
          overflow_d = ovf_q;
          valid_d    = 1'b1;
          acc_d      = acc_start;
          cnt_d      = cnt_start;
          ovf_d      = 1'b0;
`ifdef TICK_ACC_MINMAX_EN
          min_out_d = win_min_q;
          max_out_d = win_max_q;
          win_min_d = data_valid_i ? data_i : DATA_MAX;
          win_max_d = data_valid_i ? data_i : DATA_MIN;
`endif
        end else if (data_valid_i) begin
          acc_d = acc_next;
          cnt_d = cnt_next;
          ovf_d = ovf_q | acc_clamp | cnt_full;
`ifdef TICK_ACC_MINMAX_EN
          if (data_i < win_min_q) win_min_d = data_i;
          if (data_i > win_max_q) win_max_d = data_i;
`endif
        end
      end

      default: state_d = ST_WAIT;
    endcase
  end

  // prev resets high so a derived clock already high at release is not seen as an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_WAIT;
      prev_q     <= 1'b1;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      sum_q      <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
`ifdef TICK_ACC_MINMAX_EN
      win_min_q  <= DATA_MAX;
      win_max_q  <= DATA_MIN;
      min_out_q  <= '0;
      max_out_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      sum_q      <= sum_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
`ifdef TICK_ACC_MINMAX_EN
      win_min_q  <= win_min_d;
      win_max_q  <= win_max_d;
      min_out_q  <= min_out_d;
      max_out_q  <= max_out_d;
`endif
    end
  end

  assign sum_o      = sum_q;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;
  assign valid_o    = valid_q;
`ifdef TICK_ACC_MINMAX_EN
  assign min_o      = min_out_q;
  assign max_o      = max_out_q;
`endif

endmodule

// File: tb/tb_tick_window_accumulator.sv
// Bench for tick_window_accumulator: a 32-bit and a 16-bit accumulator instance share stimulus
// and are compared every cycle against a window-queue reference model.
module tb_tick_window_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               derived_clk;
  logic               data_valid_i;
  logic signed [13:0] data_i;

  logic signed [31:0] sum_a;
  logic        [23:0] count_a;
  logic               ovf_a, valid_a;
  logic signed [15:0] sum_b;
  logic        [23:0] count_b;
  logic               ovf_b, valid_b;
`ifdef TICK_ACC_MINMAX_EN
  logic signed [13:0] min_a, max_a, min_b, max_b;
`endif

  tick_window_accumulator #(.DATA_WIDTH(14), .ACC_WIDTH(32), .CNT_WIDTH(24)) dut_a (
    .clk(clk), .rst(rst), .derived_clk(derived_clk), .data_i(data_i), .data_valid_i(data_valid_i),
    .sum_o(sum_a), .count_o(count_a), .overflow_o(ovf_a), .valid_o(valid_a)
`ifdef TICK_ACC_MINMAX_EN
    , .min_o(min_a), .max_o(max_a)
`endif
  );

  tick_window_accumulator #(.DATA_WIDTH(14), .ACC_WIDTH(16), .CNT_WIDTH(24)) dut_b (
    .clk(clk), .rst(rst), .derived_clk(derived_clk), .data_i(data_i), .data_valid_i(data_valid_i),
    .sum_o(sum_b), .count_o(count_b), .overflow_o(ovf_b), .valid_o(valid_b)
`ifdef TICK_ACC_MINMAX_EN
    , .min_o(min_b), .max_o(max_b)
`endif
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: the open window is kept as a list of its samples.
  bit                 armed;
  logic               prev_m;
  logic signed [13:0] win_q[$];
  logic               exp_valid;
  logic signed [31:0] exp_sum32;
  logic signed [15:0] exp_sum16;
  logic        [23:0] exp_cnt;
  logic               exp_ovf32, exp_ovf16;
  logic signed [13:0] exp_min, exp_max;

  function automatic void window_sum(input int accw, output longint s, output bit ovf);
    longint hi = (longint'(1) <<< (accw - 1)) - 1;
    longint lo = -(longint'(1) <<< (accw - 1));
    s = 0;
    ovf = 0;
    foreach (win_q[i]) begin
      s = s + longint'(win_q[i]);
      if (s > hi) begin s = hi; ovf = 1; end
      else if (s < lo) begin s = lo; ovf = 1; end
    end
    if (win_q.size() > 24'hFFFFFF) ovf = 1;
  endfunction

  task automatic tick(input logic r, input logic d, input logic v, input logic signed [13:0] x);
    longint s;
    bit     o;
    rst = r; derived_clk = d; data_valid_i = v; data_i = x;
    @(posedge clk);
    exp_valid = 1'b0;
    if (r) begin
      armed = 0; prev_m = 1'b1; win_q.delete();
      exp_sum32 = '0; exp_sum16 = '0; exp_cnt = '0; exp_ovf32 = 0; exp_ovf16 = 0;
      exp_min = '0; exp_max = '0;
    end else begin
      if (d && !prev_m) begin
        if (armed) begin
          window_sum(32, s, o); exp_sum32 = s[31:0]; exp_ovf32 = o;
          window_sum(16, s, o); exp_sum16 = s[15:0]; exp_ovf16 = o;
          exp_cnt = (win_q.size() > 24'hFFFFFF) ? 24'hFFFFFF : 24'(win_q.size());
          exp_min = 14'sd8191;
          exp_max = -14'sd8192;
          foreach (win_q[i]) begin
            if (win_q[i] < exp_min) exp_min = win_q[i];
            if (win_q[i] > exp_max) exp_max = win_q[i];
          end
          exp_valid = 1'b1;
        end
        win_q.delete();
        if (v) win_q.push_back(x);
        armed = 1;
      end else if (armed && v) begin
        win_q.push_back(x);
      end
      prev_m = d;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, 1'b1, 14'sd5);
      n_cmp++;
      if ({valid_a, sum_a, count_a, ovf_a, valid_b, sum_b, count_b, ovf_b} !== '0) begin
        n_fail++;
        $display("[TB] FAIL reset_values cycle %0d: got a v=%0b sum=%0d cnt=%0d ovf=%0b b v=%0b sum=%0d cnt=%0d ovf=%0b, want all zero",
                 i, valid_a, sum_a, count_a, ovf_a, valid_b, sum_b, count_b, ovf_b);
      end
    end
    // Derived clock already high at release must not produce an edge.
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b1, 1'b1, 14'sd5);
      n_cmp++;
      if (valid_a !== 1'b0 || valid_b !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL reset_high_release cycle %0d: got valid %0b/%0b want 0", i, valid_a, valid_b);
      end
    end
    tick(1'b0, 1'b0, 1'b0, 14'sd0);
  endtask

  task automatic test_basic();
    logic d;
    for (int c = 0; c < 36; c++) begin
      d = ((c >= 10 && c < 20) || c >= 30);
      tick(1'b0, d, 1'b1, 14'sd5);
      n_cmp++;
      if ({valid_a, sum_a, count_a, ovf_a} !== {exp_valid, exp_sum32, exp_cnt, exp_ovf32}) begin
        n_fail++;
        $display("[TB] FAIL basic_w32 cycle %0d: got v=%0b sum=%0d cnt=%0d ovf=%0b want v=%0b sum=%0d cnt=%0d ovf=%0b",
                 c, valid_a, sum_a, count_a, ovf_a, exp_valid, exp_sum32, exp_cnt, exp_ovf32);
      end
      n_cmp++;
      if ({valid_b, sum_b, count_b, ovf_b} !== {exp_valid, exp_sum16, exp_cnt, exp_ovf16}) begin
        n_fail++;
        $display("[TB] FAIL basic_w16 cycle %0d: got v=%0b sum=%0d cnt=%0d ovf=%0b want v=%0b sum=%0d cnt=%0d ovf=%0b",
                 c, valid_b, sum_b, count_b, ovf_b, exp_valid, exp_sum16, exp_cnt, exp_ovf16);
      end
      if (c == 10) begin
        n_cmp++;
        if (valid_a !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL arming_edge: got valid %0b want 0", valid_a);
        end
      end
      if (c == 30) begin
        n_cmp++;
        if (valid_a !== 1'b1 || sum_a !== 32'sd100 || count_a !== 24'd20 || ovf_a !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL first_window: got v=%0b sum=%0d cnt=%0d ovf=%0b want v=1 sum=100 cnt=20 ovf=0",
                   valid_a, sum_a, count_a, ovf_a);
        end
      end
    end
  endtask

  task automatic test_edge_sample();
    bit d[8] = '{0, 1, 1, 0, 0, 0, 1, 1};
    bit v[8] = '{0, 1, 1, 1, 1, 1, 0, 0};
    int x[8] = '{0, 7, -3, -3, -3, -3, 0, 0};
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, d[i], v[i], 14'(x[i]));
      n_cmp++;
      if ({valid_a, sum_a, count_a, ovf_a} !== {exp_valid, exp_sum32, exp_cnt, exp_ovf32}) begin
        n_fail++;
        $display("[TB] FAIL edge_sample_w32 step %0d: got v=%0b sum=%0d cnt=%0d ovf=%0b want v=%0b sum=%0d cnt=%0d ovf=%0b",
                 i, valid_a, sum_a, count_a, ovf_a, exp_valid, exp_sum32, exp_cnt, exp_ovf32);
      end
      if (i == 6) begin
        n_cmp++;
        if (valid_a !== 1'b1 || sum_a !== -32'sd5 || count_a !== 24'd5) begin
          n_fail++;
          $display("[TB] FAIL edge_sample_window: got v=%0b sum=%0d cnt=%0d want v=1 sum=-5 cnt=5", valid_a, sum_a, count_a);
        end
      end
    end
  endtask

  task automatic test_empty();
    bit d[7] = '{0, 1, 1, 0, 0, 1, 0};
    for (int i = 0; i < 7; i++) begin
      tick(1'b0, d[i], 1'b0, 14'sd0);
      n_cmp++;
      if ({valid_b, sum_b, count_b, ovf_b} !== {exp_valid, exp_sum16, exp_cnt, exp_ovf16}) begin
        n_fail++;
        $display("[TB] FAIL empty_w16 step %0d: got v=%0b sum=%0d cnt=%0d ovf=%0b want v=%0b sum=%0d cnt=%0d ovf=%0b",
                 i, valid_b, sum_b, count_b, ovf_b, exp_valid, exp_sum16, exp_cnt, exp_ovf16);
      end
      if (i == 5) begin
        n_cmp++;
        if (valid_a !== 1'b1 || sum_a !== 32'sd0 || count_a !== 24'd0) begin
          n_fail++;
          $display("[TB] FAIL empty_window: got v=%0b sum=%0d cnt=%0d want v=1 sum=0 cnt=0", valid_a, sum_a, count_a);
        end
      end
    end
  endtask

  task automatic test_overflow();
    bit d[15] = '{0, 1, 1, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 1, 0};
    bit v[15] = '{0, 1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 0, 0};
    int x[15] = '{0, 8191, 8191, 8191, 8191, 8191, 10, 0, -8192, -8192, -8192, -8192, -8192, 0, 0};
    for (int i = 0; i < 15; i++) begin
      tick(1'b0, d[i], v[i], 14'(x[i]));
      n_cmp++;
      if ({valid_a, sum_a, count_a, ovf_a} !== {exp_valid, exp_sum32, exp_cnt, exp_ovf32}) begin
        n_fail++;
        $display("[TB] FAIL overflow_w32 step %0d: got v=%0b sum=%0d cnt=%0d ovf=%0b want v=%0b sum=%0d cnt=%0d ovf=%0b",
                 i, valid_a, sum_a, count_a, ovf_a, exp_valid, exp_sum32, exp_cnt, exp_ovf32);
      end
      n_cmp++;
      if ({valid_b, sum_b, count_b, ovf_b} !== {exp_valid, exp_sum16, exp_cnt, exp_ovf16}) begin
        n_fail++;
        $display("[TB] FAIL overflow_w16 step %0d: got v=%0b sum=%0d cnt=%0d ovf=%0b want v=%0b sum=%0d cnt=%0d ovf=%0b",
                 i, valid_b, sum_b, count_b, ovf_b, exp_valid, exp_sum16, exp_cnt, exp_ovf16);
      end
      if (i == 6) begin
        n_cmp++;
        if (sum_b !== 16'sd32767 || ovf_b !== 1'b1 || sum_a !== 32'sd40955 || ovf_a !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL pos_saturate: got sum16=%0d ovf16=%0b sum32=%0d ovf32=%0b want 32767/1 40955/0",
                   sum_b, ovf_b, sum_a, ovf_a);
        end
      end
      if (i == 8) begin
        n_cmp++;
        if (sum_b !== 16'sd10 || ovf_b !== 1'b0 || count_b !== 24'd1) begin
          n_fail++;
          $display("[TB] FAIL clean_after_ovf: got sum=%0d ovf=%0b cnt=%0d want 10/0/1", sum_b, ovf_b, count_b);
        end
      end
      if (i == 13) begin
        n_cmp++;
        if (sum_b !== -16'sd32768 || ovf_b !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL neg_saturate: got sum=%0d ovf=%0b want -32768/1", sum_b, ovf_b);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic d;
    for (int i = 0; i < 12; i++) begin
      d = (i % 2 == 0);
      tick(1'b0, d, 1'($urandom_range(0, 1)), 14'($urandom));
      n_cmp++;
      if ({valid_a, sum_a, count_a, ovf_a} !== {exp_valid, exp_sum32, exp_cnt, exp_ovf32}) begin
        n_fail++;
        $display("[TB] FAIL b2b_w32 step %0d: got v=%0b sum=%0d cnt=%0d ovf=%0b want v=%0b sum=%0d cnt=%0d ovf=%0b",
                 i, valid_a, sum_a, count_a, ovf_a, exp_valid, exp_sum32, exp_cnt, exp_ovf32);
      end
      n_cmp++;
      if (valid_b !== d) begin
        n_fail++;
        $display("[TB] FAIL b2b_strobe step %0d: got valid %0b want %0b", i, valid_b, d);
      end
    end
  endtask

  task automatic test_rst_mid();
    bit r[15] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    bit d[15] = '{0, 1, 1, 0, 1, 1, 1, 1, 1, 0, 0, 1, 1, 0, 1};
    bit v[15] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    for (int i = 0; i < 15; i++) begin
      tick(r[i], d[i], v[i], 14'sd4);
      n_cmp++;
      if ({valid_a, sum_a, count_a, ovf_a} !== {exp_valid, exp_sum32, exp_cnt, exp_ovf32}) begin
        n_fail++;
        $display("[TB] FAIL rst_mid_w32 step %0d: got v=%0b sum=%0d cnt=%0d ovf=%0b want v=%0b sum=%0d cnt=%0d ovf=%0b",
                 i, valid_a, sum_a, count_a, ovf_a, exp_valid, exp_sum32, exp_cnt, exp_ovf32);
      end
      if (i >= 2 && i <= 13) begin
        n_cmp++;
        if (valid_b !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL rst_mid_no_strobe step %0d: got valid %0b want 0", i, valid_b);
        end
      end
      if (i == 14) begin
        n_cmp++;
        if (valid_b !== 1'b1 || sum_b !== 16'sd12 || count_b !== 24'd3) begin
          n_fail++;
          $display("[TB] FAIL rst_rearm_window: got v=%0b sum=%0d cnt=%0d want v=1 sum=12 cnt=3", valid_b, sum_b, count_b);
        end
      end
    end
  endtask

`ifdef TICK_ACC_MINMAX_EN
  task automatic test_minmax();
    bit d[5] = '{0, 1, 1, 0, 1};
    bit v[5] = '{0, 1, 1, 1, 0};
    int x[5] = '{0, 3, -9, 12, 0};
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, d[i], v[i], 14'(x[i]));
      if (i == 4) begin
        n_cmp++;
        if (min_a !== -14'sd9 || max_a !== 14'sd12 || min_b !== -14'sd9 || max_b !== 14'sd12) begin
          n_fail++;
          $display("[TB] FAIL minmax: got min=%0d max=%0d want min=-9 max=12", min_a, max_a);
        end
      end
    end
  endtask
`endif

  task automatic test_random();
    int   run = 0;
    logic d = 1'b0;
    logic r;
    for (int i = 0; i < 600; i++) begin
      if (run == 0) begin
        d = ~d;
        run = $urandom_range(1, 5);
      end
      run--;
      r = ($urandom_range(0, 99) == 0);
      tick(r, d, 1'($urandom_range(0, 3) != 0), 14'($urandom));
      n_cmp++;
      if ({valid_a, sum_a, count_a, ovf_a} !== {exp_valid, exp_sum32, exp_cnt, exp_ovf32}) begin
        n_fail++;
        $display("[TB] FAIL random_w32 cycle %0d: got v=%0b sum=%0d cnt=%0d ovf=%0b want v=%0b sum=%0d cnt=%0d ovf=%0b",
                 i, valid_a, sum_a, count_a, ovf_a, exp_valid, exp_sum32, exp_cnt, exp_ovf32);
      end
      n_cmp++;
      if ({valid_b, sum_b, count_b, ovf_b} !== {exp_valid, exp_sum16, exp_cnt, exp_ovf16}) begin
        n_fail++;
        $display("[TB] FAIL random_w16 cycle %0d: got v=%0b sum=%0d cnt=%0d ovf=%0b want v=%0b sum=%0d cnt=%0d ovf=%0b",
                 i, valid_b, sum_b, count_b, ovf_b, exp_valid, exp_sum16, exp_cnt, exp_ovf16);
      end
`ifdef TICK_ACC_MINMAX_EN
      n_cmp++;
      if ({min_a, max_a} !== {exp_min, exp_max}) begin
        n_fail++;
        $display("[TB] FAIL random_minmax cycle %0d: got min=%0d max=%0d want min=%0d max=%0d",
                 i, min_a, max_a, exp_min, exp_max);
      end
`endif
    end
  endtask

  initial begin
    armed = 0;
    prev_m = 1'b1;
    exp_valid = 1'b0;
    test_reset();
    test_basic();
    test_edge_sample();
    test_empty();
    test_overflow();
    test_back_to_back();
    test_rst_mid();
`ifdef TICK_ACC_MINMAX_EN
    test_minmax();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
